// File: rtl/if_stage.sv
// if_stage: RV32I instruction-fetch stage plus IF/ID pipeline register.
// Owns the PC, fetches over a req/ready handshake with at most one request
// outstanding, parks an instruction that lands during a stall in a one-entry
// skid buffer, and drains a request orphaned by a branch redirect.
// Optional feature macro: IF_PERF_CNT_EN adds saturating stall/flush counters.
module if_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            pc_write,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]     perf_stall_cycles,
   output logic [31:0]     perf_flush_count,
`endif
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic [4:0]      if_id_rs1,
   output logic [4:0]      if_id_rs2
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,  // normal fetching from pc_q
      HOLD  = 2'd1,  // skid buffer full, waiting for the stall to drop
      DRAIN = 2'd2   // finishing a request whose data must be thrown away
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pend_q, pend_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic [31:0]     skid_instr_q, skid_instr_d;
   logic [XLEN-1:0] drain_addr_q, drain_addr_d;
   logic            if_id_valid_q, if_id_valid_d;
   logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
   logic [31:0]     if_id_instr_q, if_id_instr_d;
   logic            req_c;
   logic [XLEN-1:0] pc_inc;

   assign pc_inc = pc_q + XLEN'(4);

   // Next-state, request and IF/ID update logic for the fetch FSM.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      pend_d        = pend_q;
      skid_pc_d     = skid_pc_q;
      skid_instr_d  = skid_instr_q;
      drain_addr_d  = drain_addr_q;
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      req_c         = 1'b0;
      imem_addr     = pc_q;

      // A redirect beats a stall in every state: bubble IF/ID, retarget PC.
      if (branch_taken) begin
         if_id_valid_d = 1'b0;
         if_id_pc_d    = '0;
         if_id_instr_d = NOP_INSTR;
         pc_d          = branch_target;
      end

      unique case (state_q)
         FETCH: begin
            // A request once raised stays up until accepted, stall or not.
            req_c     = ~stall | pend_q;
            imem_addr = pc_q;
            if (branch_taken) begin
               pend_d = 1'b0;
               if (req_c && !imem_ready) begin
                  drain_addr_d = pc_q;
                  state_d      = DRAIN;
               end
            end else if (req_c && imem_ready) begin
               pend_d = 1'b0;
               pc_d   = pc_inc;
               if (!stall) begin
                  if_id_valid_d = 1'b1;
                  if_id_pc_d    = pc_q;
                  if_id_instr_d = imem_rdata;
               end else begin
                  skid_pc_d    = pc_q;
                  skid_instr_d = imem_rdata;
                  state_d      = HOLD;
               end
            end else if (req_c) begin
               pend_d = 1'b1;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               state_d = FETCH;
            end else if (!stall) begin
               if_id_valid_d = 1'b1;
               if_id_pc_d    = skid_pc_q;
               if_id_instr_d = skid_instr_q;
               state_d       = FETCH;
            end
         end
         DRAIN: begin
            req_c     = 1'b1;
            imem_addr = drain_addr_q;
            if (imem_ready) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // An abandoned request must vanish the moment reset is applied.
   assign imem_req = req_c & ~rst;

   // State and pipeline registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         pend_q        <= 1'b0;
         skid_pc_q     <= '0;
         skid_instr_q  <= NOP_INSTR;
         drain_addr_q  <= '0;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSTR;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_q        <= pend_d;
         skid_pc_q     <= skid_pc_d;
         skid_instr_q  <= skid_instr_d;
         drain_addr_q  <= drain_addr_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
      end
   end

   assign if_id_valid = if_id_valid_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_rs1   = if_id_instr_q[19:15];
   assign if_id_rs2   = if_id_instr_q[24:20];

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   // Saturating counters of stalled cycles and redirect cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stall && !branch_taken && perf_stall_q != 32'hFFFF_FFFF)
            perf_stall_q <= perf_stall_q + 32'd1;
         if (branch_taken && perf_flush_q != 32'hFFFF_FFFF)
            perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_flush_count  = perf_flush_q;
`endif

   // The hazard unit drives pc_write as the exact complement of stall.
   a_pc_write_consistent: assert property (
      @(posedge clk) disable iff (rst) pc_write == ~stall);

   // A waiting request keeps its address until it is accepted.
   a_addr_stable: assert property (
      @(posedge clk) disable iff (rst)
      (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr)));

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed-vector bench for if_stage with a combinational
// instruction-memory model and hand-computed expectations.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        pc_write;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic [4:0]  if_id_rs1;
   logic [4:0]  if_id_rs2;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .pc_write      (pc_write),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
`ifdef IF_PERF_CNT_EN
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_count  (perf_flush_count),
`endif
      .if_id_valid   (if_id_valid),
      .if_id_pc      (if_id_pc),
      .if_id_instr   (if_id_instr),
      .if_id_rs1     (if_id_rs1),
      .if_id_rs2     (if_id_rs2)
   );

   // Memory image: address 8 holds add x10,x11,x12, everything else is tagged.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h8) ? 32'h00C5_8533 : (32'hAB00_0000 | a);
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_stall(input logic s);
      stall    = s;
      pc_write = ~s;
   endtask

   task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
      check({tag, ".req"}, 32'(imem_req), 32'(req));
      if (req) check({tag, ".addr"}, imem_addr, addr);
   endtask

   task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr);
      check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
      check({tag, ".pc"}, if_id_pc, pc);
      check({tag, ".instr"}, if_id_instr, instr);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      set_stall(1'b0);
      branch_taken  = 1'b0;
      branch_target = '0;
      imem_ready    = 1'b1;
      #1 rst = 1'b1;
      #2;
      // Reset state
      check("rst.req", 32'(imem_req), 32'd0);
      chk_ifid("rst", 1'b0, 32'h0, NOP);
      tick;
      tick;
      rst = 1'b0;
      #1;

      // Zero-wait streaming from RESET_PC
      for (int i = 0; i < 4; i++) begin
         chk_req($sformatf("stream%0d", i), 1'b1, 32'(4 * i));
         tick;
         chk_ifid($sformatf("stream%0d", i), 1'b1, 32'(4 * i), mem_word(32'(4 * i)));
         if (i == 2) begin
            check("rs1", 32'(if_id_rs1), 32'd11);
            check("rs2", 32'(if_id_rs2), 32'd12);
         end
      end

      // Stall three cycles with ready high: no request, IF/ID frozen
      set_stall(1'b1);
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("stall%0d.req", i), 32'(imem_req), 32'd0);
         tick;
         chk_ifid($sformatf("stall%0d", i), 1'b1, 32'hC, mem_word(32'hC));
      end
      set_stall(1'b0);
      #1 chk_req("unstall", 1'b1, 32'h10);
      tick;
      chk_ifid("unstall", 1'b1, 32'h10, mem_word(32'h10));

      // Wait state then stall: the accepted word goes to the skid buffer
      imem_ready = 1'b0;
      #1 chk_req("wait", 1'b1, 32'h14);
      tick;
      chk_ifid("wait", 1'b1, 32'h10, mem_word(32'h10));
      set_stall(1'b1);
      imem_ready = 1'b1;
      #1 chk_req("pend_stall", 1'b1, 32'h14);
      tick;
      chk_ifid("skid_fill", 1'b1, 32'h10, mem_word(32'h10));
      check("hold1.req", 32'(imem_req), 32'd0);
      tick;
      chk_ifid("hold2", 1'b1, 32'h10, mem_word(32'h10));
      set_stall(1'b0);
      #1 check("hold_rel.req", 32'(imem_req), 32'd0);
      tick;
      chk_ifid("skid_out", 1'b1, 32'h14, mem_word(32'h14));
      chk_req("after_skid", 1'b1, 32'h18);
      tick;
      chk_ifid("after_skid", 1'b1, 32'h18, mem_word(32'h18));

      // Branch while stalled: bubble, then fetch from target
      set_stall(1'b1);
      branch_taken  = 1'b1;
      branch_target = 32'h100;
      #1 check("br_stall.req", 32'(imem_req), 32'd0);
      tick;
      chk_ifid("br_stall", 1'b0, 32'h0, NOP);
      branch_taken = 1'b0;
      set_stall(1'b0);
      #1 chk_req("br_target", 1'b1, 32'h100);
      tick;
      chk_ifid("br_target", 1'b1, 32'h100, mem_word(32'h100));

      // Branch coinciding with a transfer: data discarded
      branch_taken  = 1'b1;
      branch_target = 32'h20;
      tick;
      chk_ifid("br_xfer", 1'b0, 32'h0, NOP);

      // Request to 0x20 waits two cycles; redirect to 0x40 in the first
      branch_target = 32'h40;
      imem_ready    = 1'b0;
      #1 chk_req("drain0", 1'b1, 32'h20);
      tick;
      branch_taken = 1'b0;
      #1 chk_req("drain1", 1'b1, 32'h20);
      chk_ifid("drain1", 1'b0, 32'h0, NOP);
      tick;
      chk_req("drain2", 1'b1, 32'h20);
      imem_ready = 1'b1;
      #1 chk_req("drain_xfer", 1'b1, 32'h20);
      tick;
      chk_ifid("drain_done", 1'b0, 32'h0, NOP);
      chk_req("after_drain", 1'b1, 32'h40);
      tick;
      chk_ifid("after_drain", 1'b1, 32'h40, mem_word(32'h40));

      // PC wraps modulo 2^32
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      tick;
      branch_taken = 1'b0;
      #1 chk_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
      tick;
      chk_ifid("wrap_top", 1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
      chk_req("wrap_zero", 1'b1, 32'h0);
      tick;
      chk_ifid("wrap_zero", 1'b1, 32'h0, mem_word(32'h0));

      // Reset in the middle of a waiting request
      imem_ready = 1'b0;
      #1 chk_req("mid_wait", 1'b1, 32'h4);
      tick;
      rst = 1'b1;
      #1 check("mid_rst.req", 32'(imem_req), 32'd0);
      chk_ifid("mid_rst", 1'b0, 32'h0, NOP);
      imem_ready = 1'b1;
      tick;
      rst = 1'b0;
      #1 chk_req("post_rst", 1'b1, 32'h0);
      tick;
      chk_ifid("post_rst", 1'b1, 32'h0, mem_word(32'h0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
